// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: bus layout, control decode,
// size encodings and load FSM states.
package mem_pkg;

    localparam int unsigned EXE_MEM_W = 181;
    localparam int unsigned MEM_WB_W  = 145;

    // EXE_MEM_bus layout: {mem_control[5:0], store_data[31:0], passthrough[142:0]}
    // passthrough layout: {misc[73:0], pc[31:0], rf_wdest[4:0], exe_result[31:0]}
    localparam int unsigned CTRL_LSB   = 175;
    localparam int unsigned SDATA_LSB  = 143;
    localparam int unsigned PC_LSB     = 37;
    localparam int unsigned WDEST_LSB  = 32;
    localparam int unsigned RESULT_LSB = 0;

    localparam int unsigned CTRL_LOAD     = 5;
    localparam int unsigned CTRL_STORE    = 4;
    localparam int unsigned CTRL_SIZE_LSB = 2;
    localparam int unsigned CTRL_SIGN     = 1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // The illegal size behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size_e'(size))
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store byte enables / replicated write data,
// load lane extraction with sign/zero extension, misalignment flag.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_sign,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        misaligned_addr
);

    logic [31:0] shifted;
    logic [15:0] lane_h;

    always_comb begin
        byte_en         = 4'b1111;
        wdata           = store_data;
        load_value      = rdata;
        shifted         = rdata >> {addr_lo, 3'b000};
        lane_h          = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        misaligned_addr = misaligned(size, addr_lo);
        case (size_e'(size))
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                load_value = {{24{load_sign & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_value = {{16{load_sign & lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: EXE->MEM register, data RAM interface,
// two-cycle load FSM and MEM->WB handshake.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned DM_AW = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_over,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic                 MEM_allow_in,
    input  logic                 WB_allow_in,
    input  logic                 cancel,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [DM_AW-1:0]     dm_addr,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_pc
);

    logic                 mem_valid;
    logic                 first_cycle;
    logic [EXE_MEM_W-1:0] bus_r;
    logic [31:0]          load_data;
    state_e               state, state_nx;

    logic        is_load, is_store, load_sign, mis, aligned_load;
    logic [1:0]  size;
    logic [31:0] store_data, exe_result;
    logic        in_aligned_load, capture, preload;
    logic [31:0] in_addr, addr_sel, addr_full;
    logic [3:0]  byte_en;
    logic [31:0] load_value;

    assign is_load    = bus_r[CTRL_LSB + CTRL_LOAD];
    assign is_store   = bus_r[CTRL_LSB + CTRL_STORE];
    assign size       = bus_r[CTRL_LSB + CTRL_SIZE_LSB +: 2];
    assign load_sign  = bus_r[CTRL_LSB + CTRL_SIGN];
    assign store_data = bus_r[SDATA_LSB +: 32];
    assign exe_result = bus_r[RESULT_LSB +: 32];

    mem_align u_align (
        .size            (size),
        .addr_lo         (exe_result[1:0]),
        .load_sign       (load_sign),
        .store_data      (store_data),
        .rdata           (dm_rdata),
        .byte_en         (byte_en),
        .wdata           (dm_wdata),
        .load_value      (load_value),
        .misaligned_addr (mis)
    );

    assign aligned_load = is_load & ~mis;
    assign MEM_over     = mem_valid & (~aligned_load | (state == DONE));
    assign MEM_allow_in = ~mem_valid | (MEM_over & WB_allow_in);
    assign capture      = EXE_over & MEM_allow_in & ~cancel;

    assign in_addr         = EXE_MEM_bus[RESULT_LSB +: 32];
    assign in_aligned_load = EXE_MEM_bus[CTRL_LSB + CTRL_LOAD]
                           & ~misaligned(EXE_MEM_bus[CTRL_LSB + CTRL_SIZE_LSB +: 2], in_addr[1:0]);

    // A load accepted while leaving DONE presents its address now so it can skip
    // the IDLE address cycle and go straight to WAIT.
    assign preload   = (state == DONE) & capture & in_aligned_load;
    assign addr_sel  = preload ? in_addr : exe_result;
    assign addr_full = {addr_sel[31:2], 2'b00};
    assign dm_addr   = addr_full[DM_AW-1:0];

    assign dm_wen = (mem_valid & first_cycle & (state == IDLE) & ~cancel & is_store & ~mis)
                  ? byte_en : 4'b0000;

    always_comb begin
        state_nx = state;
        if (cancel) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (mem_valid & aligned_load) state_nx = WAIT;
                WAIT:    state_nx = DONE;
                DONE:    if (WB_allow_in) state_nx = preload ? WAIT : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            first_cycle <= 1'b0;
            bus_r       <= '0;
            load_data   <= '0;
            state       <= IDLE;
        end else begin
            state       <= state_nx;
            first_cycle <= capture;
            if (cancel)
                mem_valid <= 1'b0;
            else if (capture)
                mem_valid <= 1'b1;
            else if (MEM_over & WB_allow_in)
                mem_valid <= 1'b0;
            if (capture)
                bus_r <= EXE_MEM_bus;
            if ((state == WAIT) && !cancel)
                load_data <= load_value;
        end
    end

    assign MEM_WB_bus = {is_load & mis, is_store & mis, bus_r[SDATA_LSB-1:32],
                         aligned_load ? load_data : exe_result};
    assign MEM_wdest  = bus_r[WDEST_LSB +: 5] & {5{mem_valid}};
    assign MEM_pc     = bus_r[PC_LSB +: 32];

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a one-cycle-latency RAM model.
module tb_mem_access;

    logic         clk = 1'b0;
    logic         resetn;
    logic         EXE_over;
    logic [180:0] EXE_MEM_bus;
    logic         MEM_allow_in;
    logic         WB_allow_in;
    logic         cancel;
    logic         MEM_over;
    logic [144:0] MEM_WB_bus;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic [31:0]  dm_rdata;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;

    logic [31:0] ram [0:255];
    int checks = 0;
    int errors = 0;

    localparam logic [5:0] C_LB  = 6'b100010;
    localparam logic [5:0] C_LBU = 6'b100000;
    localparam logic [5:0] C_LH  = 6'b100110;
    localparam logic [5:0] C_LW  = 6'b101000;
    localparam logic [5:0] C_SB  = 6'b010000;
    localparam logic [5:0] C_SH  = 6'b010100;
    localparam logic [5:0] C_SW  = 6'b011000;
    localparam logic [73:0] MISC = 74'h15A5A;

    mem_access #(.DM_AW(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .MEM_allow_in (MEM_allow_in),
        .WB_allow_in  (WB_allow_in),
        .cancel       (cancel),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .MEM_wdest    (MEM_wdest),
        .MEM_pc       (MEM_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dm_rdata <= ram[dm_addr[9:2]];

    function automatic logic [180:0] mk(input logic [5:0] c, input logic [31:0] sd,
                                        input logic [31:0] a, input logic [4:0] wd,
                                        input logic [31:0] pc);
        return {c, sd, MISC, pc, wd, a};
    endfunction

    task automatic chk(input string tag, input logic [144:0] obs, input logic [144:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [180:0] b);
        EXE_over    = 1'b1;
        EXE_MEM_bus = b;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[64] = 32'h1280FF00;
        ram[65] = 32'h80011234;
        ram[66] = 32'h11223344;
        ram[67] = 32'hCAFEF00D;
        dm_rdata    = 32'h0;
        resetn      = 1'b0;
        EXE_over    = 1'b0;
        EXE_MEM_bus = '0;
        WB_allow_in = 1'b1;
        cancel      = 1'b0;
        #3;
        chk("rst_over",    MEM_over, 0);
        chk("rst_allow",   MEM_allow_in, 1);
        chk("rst_wen",     dm_wen, 0);
        chk("rst_wdest",   MEM_wdest, 0);
        chk("rst_pc",      MEM_pc, 0);
        chk("rst_wb_bus",  MEM_WB_bus, 0);
        tick; tick;
        resetn = 1'b1;

        // SB 0x103
        offer(mk(C_SB, 32'h000000A5, 32'h103, 5'd7, 32'h1000));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("sb_wen",    dm_wen, 4'b1000);
        chk("sb_wdata",  dm_wdata, 32'hA5A5A5A5);
        chk("sb_addr",   dm_addr, 32'h100);
        chk("sb_over",   MEM_over, 1);
        chk("sb_wdest",  MEM_wdest, 5'd7);
        chk("sb_pc",     MEM_pc, 32'h1000);
        chk("sb_wb_bus", MEM_WB_bus, {2'b00, MISC, 32'h1000, 5'd7, 32'h103});
        tick;
        chk("sb_wen_once", dm_wen, 0);
        chk("sb_retired",  MEM_over, 0);

        // LB signed 0x102, then back-to-back LBU 0x102 and LH 0x106
        offer(mk(C_LB, 32'h0, 32'h102, 5'd3, 32'h1004));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("lb_c1_over",  MEM_over, 0);
        chk("lb_c1_allow", MEM_allow_in, 0);
        chk("lb_c1_wen",   dm_wen, 0);
        tick;
        chk("lb_c2_over",  MEM_over, 0);
        tick;
        chk("lb_over",     MEM_over, 1);
        chk("lb_result",   MEM_WB_bus[31:0], 32'hFFFFFF80);
        chk("lb_adel",     MEM_WB_bus[144:143], 2'b00);
        offer(mk(C_LBU, 32'h0, 32'h102, 5'd4, 32'h1008));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("lbu_c1_over", MEM_over, 0);
        tick;
        chk("lbu_over",    MEM_over, 1);
        chk("lbu_result",  MEM_WB_bus[31:0], 32'h00000080);
        offer(mk(C_LH, 32'h0, 32'h106, 5'd5, 32'h100C));
        #1;
        chk("lh_preaddr",  dm_addr, 32'h104);
        tick;
        EXE_over = 1'b0;
        #1;
        chk("lh_c1_over",  MEM_over, 0);
        tick;
        chk("lh_over",     MEM_over, 1);
        chk("lh_result",   MEM_WB_bus[31:0], 32'hFFFF8001);
        tick;
        chk("lh_retired",  MEM_over, 0);

        // Misaligned LW 0x106, SH 0x101, then aligned SW back to back
        offer(mk(C_LW, 32'h0, 32'h106, 5'd6, 32'h1010));
        tick;
        offer(mk(C_SH, 32'h1234, 32'h101, 5'd0, 32'h1014));
        #1;
        chk("lw_mis_over",   MEM_over, 1);
        chk("lw_mis_flags",  MEM_WB_bus[144:143], 2'b10);
        chk("lw_mis_wen",    dm_wen, 0);
        chk("lw_mis_result", MEM_WB_bus[31:0], 32'h106);
        tick;
        offer(mk(C_SW, 32'hDEADBEEF, 32'h10C, 5'd0, 32'h1018));
        #1;
        chk("sh_mis_flags",  MEM_WB_bus[144:143], 2'b01);
        chk("sh_mis_wen",    dm_wen, 0);
        chk("sh_mis_over",   MEM_over, 1);
        tick;
        EXE_over = 1'b0;
        #1;
        chk("sw_wen",        dm_wen, 4'b1111);
        chk("sw_wdata",      dm_wdata, 32'hDEADBEEF);
        tick;

        // Store under back-pressure writes once
        WB_allow_in = 1'b0;
        offer(mk(C_SH, 32'h0000BEEF, 32'h112, 5'd1, 32'h101C));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("sh_bp_wen1",  dm_wen, 4'b1100);
        chk("sh_bp_wdata", dm_wdata, 32'hBEEFBEEF);
        tick;
        chk("sh_bp_wen2",  dm_wen, 0);
        chk("sh_bp_over",  MEM_over, 1);
        WB_allow_in = 1'b1;
        tick;

        // LW 0x108 completes under back-pressure while RAM changes
        WB_allow_in = 1'b0;
        offer(mk(C_LW, 32'h0, 32'h108, 5'd9, 32'h1020));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("lw_bp_allow_c1", MEM_allow_in, 0);
        tick;
        chk("lw_bp_allow_c2", MEM_allow_in, 0);
        tick;
        ram[66] = 32'h55667788;
        for (int i = 0; i < 3; i++) begin
            chk("lw_bp_over",   MEM_over, 1);
            chk("lw_bp_allow",  MEM_allow_in, 0);
            chk("lw_bp_result", MEM_WB_bus[31:0], 32'h11223344);
            tick;
        end
        WB_allow_in = 1'b1;
        #1;
        chk("lw_bp_release", MEM_allow_in, 1);
        tick;
        chk("lw_bp_retired", MEM_over, 0);

        // Cancel: offered store blocked, held store's write suppressed
        offer(mk(C_SW, 32'h12345678, 32'h114, 5'd2, 32'h1024));
        cancel = 1'b1;
        tick;
        EXE_over = 1'b0;
        cancel   = 1'b0;
        #1;
        chk("cancel_cap_over", MEM_over, 0);
        chk("cancel_cap_wen",  dm_wen, 0);
        offer(mk(C_SW, 32'h12345678, 32'h114, 5'd2, 32'h1024));
        tick;
        EXE_over = 1'b0;
        cancel   = 1'b1;
        #1;
        chk("cancel_wen",     dm_wen, 0);
        tick;
        cancel = 1'b0;
        #1;
        chk("cancel_valid",   MEM_over, 0);
        chk("cancel_wdest",   MEM_wdest, 0);
        chk("cancel_allow",   MEM_allow_in, 1);

        // Reset during WAIT, then a fresh LW
        offer(mk(C_LW, 32'h0, 32'h10C, 5'd8, 32'h1028));
        tick;
        EXE_over = 1'b0;
        tick;
        resetn = 1'b0;
        #1;
        chk("midrst_over",  MEM_over, 0);
        chk("midrst_allow", MEM_allow_in, 1);
        chk("midrst_bus",   MEM_WB_bus, 0);
        chk("midrst_pc",    MEM_pc, 0);
        chk("midrst_wdest", MEM_wdest, 0);
        chk("midrst_wen",   dm_wen, 0);
        chk("midrst_addr",  dm_addr, 0);
        tick;
        resetn = 1'b1;
        offer(mk(C_LW, 32'h0, 32'h10C, 5'd8, 32'h1028));
        tick;
        EXE_over = 1'b0;
        #1;
        chk("postrst_c1", MEM_over, 0);
        tick;
        chk("postrst_c2", MEM_over, 0);
        tick;
        chk("postrst_over",   MEM_over, 1);
        chk("postrst_result", MEM_WB_bus[31:0], 32'hCAFEF00D);
        chk("postrst_wdest",  MEM_wdest, 5'd8);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
